pulse_share_arbiter: RTL and testbench
======================================

Name: pulse_share_arbiter

Overview:
- Shares one timed one-shot pulse engine among N trigger channels.
- Each channel's rising edge becomes a pending request. A round-robin arbiter grants one request at a time.
- The granted channel gets a fixed-width output pulse, followed by a programmable hold-off gap.
- Sits between raw trigger sources (buttons, sensor strobes) and downstream logic that must never see two channel pulses at once.

Parameters:
- N, 4, number of trigger channels (2..16).
- CW, 4, width of the pulse-width and hold-off counters/config.
- IDW, 2, width of grant_id; must satisfy 2**IDW >= N.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- trig  input  N  per-channel trigger levels; a 0->1 sampled transition requests a pulse.
- width_cfg  input  CW  pulse length in clk cycles; 0 is treated as 1.
- holdoff_cfg  input  CW  idle gap after each pulse in clk cycles; 0 means no gap.
- clear_drop  input  1  synchronous clear of all drop flags.
- pulse_vec  output  N  one-hot pulse on the granted channel, all zero otherwise.
- pulse_any  output  1  OR of pulse_vec.
- grant_id  output  IDW  index of the last granted channel; holds its value between grants.
- busy  output  1  high in PULSE or HOLDOFF.
- pending  output  N  per-channel outstanding requests.
- drop  output  N  sticky flag per channel: a request was lost.

Behaviour:
- Reset (reset_n=0, effective immediately):
  - state=IDLE; pulse_vec, pulse_any, grant_id, busy, pending and drop all 0.
  - Round-robin pointer and edge-history registers are 0.
- Edge detect:
  - prev_trig is registered each cycle.
  - edge[i] = trig[i] & ~prev_trig[i].
  - edge[i] sets pending[i] at that clock edge.
- Drop: edge[i] while pending[i] is already 1 and not being cleared in the same cycle sets drop[i]. pending[i] stays 1.
- Same-cycle grant and edge: edge[i] in the same cycle channel i is granted clears the old request and re-sets pending[i] (set wins). No drop is flagged.
- clear_drop=1 clears all drop bits. A drop event in the same cycle takes priority and the bit ends at 1.
- FSM states: IDLE, PULSE, HOLDOFF.
- IDLE:
  - If any pending bit is set, select the first set bit searching from ptr upward, with wrap-around modulo N.
  - Clear that pending bit, latch grant_id=winner, set ptr=(winner+1) mod N.
  - Latch wlen=max(width_cfg,1) and hlen=holdoff_cfg; config is sampled only here.
  - Load the counter and move to PULSE.
  - With no pending bits, stay in IDLE.
- PULSE:
  - pulse_vec[grant_id]=1, registered output.
  - Counter increments each cycle. At count==wlen-1, go to HOLDOFF if hlen!=0, otherwise IDLE.
  - The pulse is high for exactly wlen cycles.
- HOLDOFF: pulse_vec=0, busy=1. After exactly hlen cycles, go to IDLE.
- Latency and throughput:
  - trig first sampled high at edge k, so pending is set at k, PULSE is entered at k+1, and pulse_vec is high from k+1 through k+wlen.
  - Minimum spacing between successive grants is wlen+hlen+1 cycles. One IDLE arbitration cycle always occurs between grants.
- A trig held high generates one request only; a new request needs a fall then a rise.
- Counter arithmetic is unsigned CW-bit and never overflows because the comparison is against wlen-1 or hlen-1.
- Mid-operation reset aborts the pulse immediately and discards all pending requests.

Optional Feature:
- Macro TRIG_SYNC_EN.
- Defined: each trig bit passes through a 2-flop synchronizer (reset to 0) before edge detection. All trig-to-pending and trig-to-pulse latencies grow by 2 cycles.
- Undefined: trig is sampled directly and assumed synchronous to clk.

Test Plan (N=4, CW=4, TRIG_SYNC_EN undefined unless stated):
1. Single channel: width_cfg=3, holdoff_cfg=2, trig[1] rises at edge k -> pending[1]=1 at k; pulse_vec=4'b0010 for edges k+1..k+3; busy low after k+5; grant_id=1.
2. Simultaneous: trig=4'b1011 rises together, ptr=0, width_cfg=1, holdoff_cfg=0 -> pulses granted in order ch0, ch1, ch3, each 1 cycle wide, 2 cycles apart; drop=0.
3. Round-robin fairness: ch0 and ch2 re-trigger after every one of their own pulses -> grants alternate 0,2,0,2; neither channel is granted twice in a row.
4. Drop and clear: second rising edge on trig[2] while pending[2]=1 and busy -> drop[2]=1 and only one pulse is produced; assert clear_drop -> drop=0 the next cycle.
5. Boundary: width_cfg=0 -> 1-cycle pulse; width_cfg=15, holdoff_cfg=15 -> 15 cycles high, 15 cycles gap; width_cfg changed mid-pulse -> no effect on the current pulse.
6. Reset mid-PULSE: reset_n=0 for 1 cycle while pulse_vec=4'b0100 and pending=4'b1001 -> all outputs 0 immediately; no pulses after release until new edges. With TRIG_SYNC_EN defined, repeat scenario 1 and confirm pulse start at k+3.

Source files
------------

// File: rtl/pulse_share_arbiter_if.sv
// Trigger/config inputs and pulse/status outputs of pulse_share_arbiter.
// The driver of trig and the config uses master; the arbiter uses slave.
interface pulse_share_arbiter_if #(
   parameter int N   = 4,
   parameter int CW  = 4,
   parameter int IDW = 2
);
   logic [N-1:0]   trig;
   logic [CW-1:0]  width_cfg;
   logic [CW-1:0]  holdoff_cfg;
   logic           clear_drop;
   logic [N-1:0]   pulse_vec;
   logic           pulse_any;
   logic [IDW-1:0] grant_id;
   logic           busy;
   logic [N-1:0]   pending;
   logic [N-1:0]   drop;

   modport master (output trig, width_cfg, holdoff_cfg, clear_drop,
                   input  pulse_vec, pulse_any, grant_id, busy, pending, drop);
   modport slave  (input  trig, width_cfg, holdoff_cfg, clear_drop,
                   output pulse_vec, pulse_any, grant_id, busy, pending, drop);
endinterface

// File: rtl/pulse_share_arbiter.sv
// Round-robin sharing of one one-shot pulse engine among N rising-edge triggers.
// Define TRIG_SYNC_EN to pass each trig bit through a 2-flop synchronizer first.
module pulse_share_arbiter #(
   parameter int N   = 4,
   parameter int CW  = 4,
   parameter int IDW = 2
) (
   input logic                  clk,
   input logic                  reset_n,
   pulse_share_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   trig_s, prev_q, trig_rise;
   logic [N-1:0]   pending_q, pending_d, drop_q, drop_d, drop_set;
   logic [N-1:0]   pulse_q, pulse_d, grant_clr, win_onehot;
   logic [IDW-1:0] ptr_q, ptr_d, gid_q, gid_d, win_idx, hi_idx, lo_idx;
   logic [CW-1:0]  cnt_q, cnt_d, wlen_q, wlen_d, hlen_q, hlen_d;
   logic           hi_found, lo_found, grant;

`ifdef TRIG_SYNC_EN
   logic [N-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= bus.trig;
         sync2_q <= sync1_q;
      end
   end

   assign trig_s = sync2_q;
`else
   assign trig_s = bus.trig;
`endif

   assign trig_rise = trig_s & ~prev_q;

   // Lowest set bit at or above ptr wins; otherwise wrap to the lowest set bit overall.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no latch can be inferred.
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            lo_found = 1'b1;
            lo_idx   = IDW'(i);
            if (i >= int'(ptr_q)) begin
               hi_found = 1'b1;
               hi_idx   = IDW'(i);
            end
         end
      end
      win_idx    = hi_found ? hi_idx : lo_idx;
      win_onehot = N'(1) << win_idx;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wlen_d  = wlen_q;
      hlen_d  = hlen_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      pulse_d = pulse_q;
      grant   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (lo_found) begin
               grant   = 1'b1;
               gid_d   = win_idx;
               ptr_d   = (win_idx == IDW'(N - 1)) ? '0 : win_idx + IDW'(1);
               wlen_d  = (bus.width_cfg == '0) ? CW'(1) : bus.width_cfg;
               hlen_d  = bus.holdoff_cfg;
               cnt_d   = '0;
               pulse_d = win_onehot;
               state_d = PULSE;
            end
         end
         PULSE: begin
            if (cnt_q == wlen_q - CW'(1)) begin
               cnt_d   = '0;
               pulse_d = '0;
               state_d = (hlen_q != '0) ? HOLDOFF : IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         HOLDOFF: begin
            if (cnt_q == hlen_q - CW'(1)) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A new edge on the channel being granted re-arms it instead of counting as a drop.
   assign grant_clr = grant ? win_onehot : '0;
   assign drop_set  = trig_rise & pending_q & ~grant_clr;
   assign pending_d = (pending_q & ~grant_clr) | trig_rise;
   assign drop_d    = (bus.clear_drop ? '0 : drop_q) | drop_set;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         prev_q    <= '0;
         pending_q <= '0;
         drop_q    <= '0;
         pulse_q   <= '0;
         ptr_q     <= '0;
         gid_q     <= '0;
         cnt_q     <= '0;
         wlen_q    <= '0;
         hlen_q    <= '0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values.
         state_q   <= state_d;
         prev_q    <= trig_s;
         pending_q <= pending_d;
         drop_q    <= drop_d;
         pulse_q   <= pulse_d;
         ptr_q     <= ptr_d;
         gid_q     <= gid_d;
         cnt_q     <= cnt_d;
         wlen_q    <= wlen_d;
         hlen_q    <= hlen_d;
      end
   end

   assign bus.pulse_vec = pulse_q;
   assign bus.pulse_any = |pulse_q;
   assign bus.grant_id  = gid_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.pending   = pending_q;
   assign bus.drop      = drop_q;
endmodule

// File: tb/tb_pulse_share_arbiter.sv
// Bench for pulse_share_arbiter: cycle tables, hand-written corner sequences and
// random traffic checked against a countdown-based reference model.
module tb_pulse_share_arbiter;
   localparam int N   = 4;
   localparam int CW  = 4;
   localparam int IDW = 2;
`ifdef TRIG_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   pulse_share_arbiter_if #(.N(N), .CW(CW), .IDW(IDW)) bus ();
   pulse_share_arbiter #(.N(N), .CW(CW), .IDW(IDW)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a request set, a pointer and two countdowns (pulse, gap).
   bit [N-1:0] m_pend, m_drop, m_prev, m_s1, m_s2, m_t, m_e, m_gclr;
   int m_gid, m_ptr, m_prem, m_grem, m_hlen, m_idx;

   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         m_pend = '0; m_drop = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
         m_gid = 0; m_ptr = 0; m_prem = 0; m_grem = 0; m_hlen = 0;
      end else begin
`ifdef TRIG_SYNC_EN
         m_t  = m_s2;
         m_s2 = m_s1;
         m_s1 = bus.trig;
`else
         m_t  = bus.trig;
`endif
         m_e    = m_t & ~m_prev;
         m_prev = m_t;
         m_gclr = '0;
         if (m_prem == 0 && m_grem == 0) begin
            if (m_pend != '0) begin
               for (int k = 0; k < N; k++) begin
                  m_idx = (m_ptr + k) % N;
                  if (m_pend[m_idx] && m_gclr == '0) begin
                     m_gclr[m_idx] = 1'b1;
                     m_gid = m_idx;
                  end
               end
               m_ptr  = (m_gid + 1) % N;
               m_prem = (bus.width_cfg == 0) ? 1 : int'(bus.width_cfg);
               m_hlen = int'(bus.holdoff_cfg);
            end
         end else if (m_prem > 0) begin
            m_prem--;
            if (m_prem == 0) m_grem = m_hlen;
         end else begin
            m_grem--;
         end
         m_drop = (bus.clear_drop ? '0 : m_drop) | (m_e & m_pend & ~m_gclr);
         m_pend = (m_pend & ~m_gclr) | m_e;
      end
   end

   function automatic logic [15:0] dut_obs();
      return {bus.pulse_vec, bus.pulse_any, bus.grant_id, bus.busy, bus.pending, bus.drop};
   endfunction

   function automatic logic [15:0] model_obs();
      logic [N-1:0] pv;
      pv = (m_prem > 0) ? (N'(1) << m_gid) : '0;
      return {pv, |pv, IDW'(m_gid), (m_prem > 0 || m_grem > 0), m_pend, m_drop};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      check("model", 32'(dut_obs()), 32'(model_obs()));
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      bus.trig = '0; bus.clear_drop = 1'b0; bus.width_cfg = '0; bus.holdoff_cfg = '0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   typedef struct {
      logic [N-1:0]   trig;
      logic [N-1:0]   pulse;
      logic [IDW-1:0] gid;
      logic           busy;
      logic [N-1:0]   pend;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(logic [N-1:0] t, logic [N-1:0] p, int g, bit b, logic [N-1:0] pe);
      vec_t v;
      v.trig = t; v.pulse = p; v.gid = IDW'(g); v.busy = b; v.pend = pe;
      tbl.push_back(v);
   endfunction

   // Only trig passes through the synchronizer, so its outputs trail the table by SYNC_LAT rows.
   task automatic run_table(input string tag, input int w, input int h);
      vec_t v;
      int   last;
      do_reset();
      bus.width_cfg = CW'(w); bus.holdoff_cfg = CW'(h);
      last = tbl.size() - 1;
      for (int r = 0; r < tbl.size() + SYNC_LAT; r++) begin
         bus.trig = tbl[(r < last) ? r : last].trig;
         tick();
         if (r >= SYNC_LAT) begin
            v = tbl[r - SYNC_LAT];
            check($sformatf("%s_row%0d", tag, r - SYNC_LAT), 32'(dut_obs()),
                  32'({v.pulse, |v.pulse, v.gid, v.busy, v.pend, 4'b0000}));
         end
      end
      tbl.delete();
   endtask

   task automatic run_pulse(input int ch, input int w, input int h, input int w_mid,
                            output int hi, output int gap);
      bus.width_cfg = CW'(w); bus.holdoff_cfg = CW'(h); bus.trig[ch] = 1'b1;
      hi = 0; gap = 0;
      for (int c = 0; c < 80; c++) begin
         tick();
         if (bus.pulse_vec[ch]) begin
            hi++;
            if (hi == 2) bus.width_cfg = CW'(w_mid);
         end else if (bus.busy && hi > 0) begin
            gap++;
         end
         if (hi > 0 && !bus.busy) break;
      end
      bus.trig[ch] = 1'b0;
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 2 ms");
      $fatal(1, "watchdog");
   end

   initial begin
      int grants[4];
      int ng, rises, hi, gap;
      logic prev_p2;

      do_reset();
      check("reset_state", 32'(dut_obs()), 32'h0);

      // Single channel: width 3, hold-off 2.
      add(4'b0010, 4'b0000, 0, 0, 4'b0010);
      add(4'b0010, 4'b0010, 1, 1, 4'b0000);
      add(4'b0000, 4'b0010, 1, 1, 4'b0000);
      add(4'b0000, 4'b0010, 1, 1, 4'b0000);
      add(4'b0000, 4'b0000, 1, 1, 4'b0000);
      add(4'b0000, 4'b0000, 1, 1, 4'b0000);
      add(4'b0000, 4'b0000, 1, 0, 4'b0000);
      add(4'b0000, 4'b0000, 1, 0, 4'b0000);
      run_table("single", 3, 2);

      // Simultaneous rise on 0,1,3: grants 0,1,3 two cycles apart.
      add(4'b1011, 4'b0000, 0, 0, 4'b1011);
      add(4'b1011, 4'b0001, 0, 1, 4'b1010);
      add(4'b1011, 4'b0000, 0, 0, 4'b1010);
      add(4'b1011, 4'b0010, 1, 1, 4'b1000);
      add(4'b1011, 4'b0000, 1, 0, 4'b1000);
      add(4'b1011, 4'b1000, 3, 1, 4'b0000);
      add(4'b0000, 4'b0000, 3, 0, 4'b0000);
      add(4'b0000, 4'b0000, 3, 0, 4'b0000);
      run_table("simul", 1, 0);

      // Fairness: ch0 and ch2 re-trigger after each of their own pulses.
      do_reset();
      bus.width_cfg = 4'd1; bus.holdoff_cfg = 4'd0;
      foreach (grants[k]) grants[k] = -1;
      ng = 0;
      bus.trig = 4'b0101;
      for (int c = 0; c < 80 && ng < 4; c++) begin
         tick();
         if (bus.pulse_any) begin
            grants[ng] = int'(bus.grant_id);
            ng++;
            bus.trig[bus.grant_id] = 1'b0;
         end else begin
            bus.trig = 4'b0101;
         end
      end
      check("fair_g0", 32'(grants[0]), 32'd0);
      check("fair_g1", 32'(grants[1]), 32'd2);
      check("fair_g2", 32'(grants[2]), 32'd0);
      check("fair_g3", 32'(grants[3]), 32'd2);

      // Drop: ch2 rises twice while its first request is still queued behind ch0.
      do_reset();
      bus.width_cfg = 4'd4; bus.holdoff_cfg = 4'd2;
      bus.trig = 4'b0001; tick(); tick();
      bus.trig = 4'b0101; tick();
      bus.trig = 4'b0001; tick();
      bus.trig = 4'b0101; tick();
      repeat (SYNC_LAT) tick();
      check("drop_set", 32'(bus.drop), 32'b0100);
      check("drop_pend", 32'(bus.pending), 32'b0100);
      bus.trig = 4'b0000;
      rises = 0; prev_p2 = 1'b0;
      for (int c = 0; c < 25; c++) begin
         tick();
         if (bus.pulse_vec[2] && !prev_p2) rises++;
         prev_p2 = bus.pulse_vec[2];
      end
      check("drop_one_pulse", 32'(rises), 32'd1);
      check("drop_sticky", 32'(bus.drop), 32'b0100);
      bus.clear_drop = 1'b1; tick();
      bus.clear_drop = 1'b0;
      check("drop_cleared", 32'(bus.drop), 32'b0000);

      // Width/hold-off boundaries and mid-pulse config change.
      do_reset();
      run_pulse(1, 0, 0, 0, hi, gap);
      check("w0_high", 32'(hi), 32'd1);
      check("w0_gap", 32'(gap), 32'd0);
      run_pulse(3, 15, 15, 15, hi, gap);
      check("w15_high", 32'(hi), 32'd15);
      check("h15_gap", 32'(gap), 32'd15);
      run_pulse(0, 5, 1, 1, hi, gap);
      check("wmid_high", 32'(hi), 32'd5);
      check("wmid_gap", 32'(gap), 32'd1);

      // Reset while ch2 pulses with ch0/ch3 queued.
      do_reset();
      bus.width_cfg = 4'd6; bus.holdoff_cfg = 4'd0;
      bus.trig = 4'b0100;
      repeat (2 + SYNC_LAT) tick();
      bus.trig = 4'b1101;
      repeat (1 + SYNC_LAT) tick();
      check("rst_pre_pulse", 32'(bus.pulse_vec), 32'b0100);
      check("rst_pre_pend", 32'(bus.pending), 32'b1001);
      reset_n = 1'b0; bus.trig = 4'b0000;
      #1;
      check("rst_async", 32'(dut_obs()), 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      rises = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (bus.pulse_any) rises++;
      end
      check("rst_no_pulse", 32'(rises), 32'd0);
      bus.trig = 4'b0010;
      repeat (4 + SYNC_LAT) tick();
      bus.trig = 4'b0000;

      // Random traffic against the model, including config churn and rare resets.
      for (int c = 0; c < 600; c++) begin
         bus.trig        = bus.trig ^ (4'($urandom) & 4'($urandom));
         bus.width_cfg   = CW'($urandom_range(0, 5));
         bus.holdoff_cfg = CW'($urandom_range(0, 3));
         bus.clear_drop  = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 199) == 0) begin
            reset_n = 1'b0;
            tick();
            reset_n = 1'b1;
         end else begin
            tick();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
